// File: rtl/fetch_unit_if.sv
// Fetch-side bus: async instruction ROM port plus the IF->ID valid/ready output register.
// master = fetch_unit (drives rom_addr, if_*), slave = ROM/decode side (drives rom_inst, id_ready).
interface fetch_unit_if #(
  parameter int ROM_AW = 5
);
  logic [ROM_AW-1:0] rom_addr;
  logic [31:0]       rom_inst;
  logic              if_valid;
  logic [31:0]       if_inst;
  logic [31:0]       if_pc;
  logic              id_ready;

  modport master (
    output rom_addr,
    input  rom_inst,
    output if_valid,
    output if_inst,
    output if_pc,
    input  id_ready
  );

  modport slave (
    input  rom_addr,
    output rom_inst,
    input  if_valid,
    input  if_inst,
    input  if_pc,
    output id_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, async ROM addressing, IF->ID register with valid/ready, redirects.
// Ports: clk, resetn (sync, active-low), fetch_en, redirect_valid/redirect_target, bus (master),
// pc, fetch_err; perf_fetch_cnt/perf_stall_cnt/perf_flush_cnt only when FETCH_PERF_EN is defined.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ROM_AW   = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_target,
  fetch_unit_if.master      bus,
`ifdef FETCH_PERF_EN
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt,
`endif
  output logic [31:0]       pc,
  output logic              fetch_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;

  logic        in_window;
  logic [31:0] fetched;
  logic [31:0] pc_next;
  logic        slot_free;
  logic        transfer;
  logic        redir;
  logic        misalign;
  logic        load;

  assign bus.rom_addr = pc[ROM_AW+1:2];
  assign bus.if_valid = if_valid;
  assign bus.if_inst  = if_inst;
  assign bus.if_pc    = if_pc;

  // Anything above the ROM window reads as a NOP rather than aliasing.
  assign in_window = (pc[31:ROM_AW+2] == '0);
  assign fetched   = in_window ? bus.rom_inst : 32'h0000_0000;
  assign pc_next   = pc + 32'd4;

  assign slot_free = !if_valid || bus.id_ready;
  assign transfer  = if_valid && bus.id_ready;

  // HALT swallows redirects entirely.
  assign redir    = redirect_valid && (state != HALT);
  assign misalign = redir && (redirect_target[1:0] != 2'b00);
  assign load     = (state == FETCH) && fetch_en && slot_free
                    && !redirect_valid;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      if_valid  <= 1'b0;
      if_inst   <= 32'h0;
      if_pc     <= 32'h0;
      fetch_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (misalign)      state <= HALT;
          else if (fetch_en) state <= FETCH;
        end
        FETCH: begin
          if (misalign)       state <= HALT;
          else if (!fetch_en) state <= IDLE;
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase

      // Redirect outranks load; a flush wins even over a same-cycle transfer.
      if (misalign) begin
        if_valid  <= 1'b0;
        fetch_err <= 1'b1;
      end else if (redir) begin
        pc       <= redirect_target;
        if_valid <= 1'b0;
      end else if (load) begin
        if_inst  <= fetched;
        if_pc    <= pc;
        if_valid <= 1'b1;
        pc       <= pc_next;
      end else if (transfer) begin
        if_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic stall;
  logic flush;

  assign stall = if_valid && !bus.id_ready;
  assign flush = redir && !misalign && if_valid;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_fetch_cnt <= 32'h0;
      perf_stall_cnt <= 32'h0;
      perf_flush_cnt <= 32'h0;
    end else begin
      if (load)  perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit with a small async ROM model.
// Covers streaming, stall, redirect/flush, misaligned halt, window/wrap, mid-stall reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] pc;
  logic        fetch_err;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  fetch_unit_if #(.ROM_AW(5)) bus ();

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .ROM_AW   (5)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .fetch_en        (fetch_en),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .bus             (bus.master),
`ifdef FETCH_PERF_EN
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_flush_cnt  (perf_flush_cnt),
`endif
    .pc              (pc),
    .fetch_err       (fetch_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    unique case (bus.rom_addr)
      5'd0:    bus.rom_inst = 32'h2401000A;
      5'd1:    bus.rom_inst = 32'h24020014;
      5'd2:    bus.rom_inst = 32'h00221821;
      5'd5:    bus.rom_inst = 32'h00853024;
      default: bus.rom_inst = 32'h0000_0000;
    endcase
  end

  typedef struct {
    logic        rst;
    logic        fe;
    logic        rdy;
    logic        rv;
    logic [31:0] tgt;
    logic        ev;
    logic [31:0] eipc;
    logic [31:0] einst;
    logic [31:0] epc;
    logic        eerr;
    logic        pchk;
    logic [31:0] efc;
    logic [31:0] esc;
    logic [31:0] eflc;
  } row_t;

  row_t tab[$];

  function automatic row_t mk(
    input logic rst, input logic fe, input logic rdy,
    input logic rv, input logic [31:0] tgt,
    input logic ev, input logic [31:0] eipc,
    input logic [31:0] einst, input logic [31:0] epc,
    input logic eerr, input logic pchk,
    input logic [31:0] efc, input logic [31:0] esc,
    input logic [31:0] eflc);
    row_t r;
    r.rst = rst; r.fe = fe; r.rdy = rdy;
    r.rv = rv; r.tgt = tgt;
    r.ev = ev; r.eipc = eipc; r.einst = einst;
    r.epc = epc; r.eerr = eerr; r.pchk = pchk;
    r.efc = efc; r.esc = esc; r.eflc = eflc;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h",
               nm, idx, act, exp);
    end
  endtask

  task automatic run_row(input row_t r, input int idx);
    logic [31:0] ra;
    resetn          = r.rst;
    fetch_en        = r.fe;
    bus.id_ready    = r.rdy;
    redirect_valid  = r.rv;
    redirect_target = r.tgt;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    ra = {27'd0, bus.rom_addr};
    chk("if_valid", idx, {31'd0, bus.if_valid}, {31'd0, r.ev});
    chk("if_pc", idx, bus.if_pc, r.eipc);
    chk("if_inst", idx, bus.if_inst, r.einst);
    chk("pc", idx, pc, r.epc);
    chk("rom_addr", idx, ra, {27'd0, r.epc[6:2]});
    chk("fetch_err", idx, {31'd0, fetch_err}, {31'd0, r.eerr});
`ifdef FETCH_PERF_EN
    if (r.pchk) begin
      chk("perf_fetch", idx, perf_fetch_cnt, r.efc);
      chk("perf_stall", idx, perf_stall_cnt, r.esc);
      chk("perf_flush", idx, perf_flush_cnt, r.eflc);
    end
`endif
  endtask

  initial begin
    resetn          = 1'b0;
    fetch_en        = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    bus.id_ready    = 1'b1;

    // rst fe rdy rv tgt | v ifpc inst pc err | perf
    tab.push_back(mk(0,0,1,0,32'h0,  0,32'h0,32'h0,32'h0,0, 1,0,0,0));
    tab.push_back(mk(1,1,1,0,32'h0,  0,32'h0,32'h0,32'h0,0, 0,0,0,0));
    tab.push_back(mk(1,1,1,0,32'h0,  1,32'h0,32'h2401000A,32'h4,0, 0,0,0,0));
    tab.push_back(mk(1,1,1,0,32'h0,  1,32'h4,32'h24020014,32'h8,0, 0,0,0,0));
    tab.push_back(mk(1,1,1,0,32'h0,  1,32'h8,32'h00221821,32'hC,0, 0,0,0,0));
    tab.push_back(mk(1,1,1,1,32'h4,  0,32'h8,32'h00221821,32'h4,0, 0,0,0,0));
    tab.push_back(mk(1,1,1,0,32'h0,  1,32'h4,32'h24020014,32'h8,0, 0,0,0,0));
    tab.push_back(mk(1,1,0,0,32'h0,  1,32'h4,32'h24020014,32'h8,0, 0,0,0,0));
    tab.push_back(mk(1,1,0,0,32'h0,  1,32'h4,32'h24020014,32'h8,0, 0,0,0,0));
    tab.push_back(mk(1,1,0,0,32'h0,  1,32'h4,32'h24020014,32'h8,0, 0,0,0,0));
    tab.push_back(mk(1,1,1,0,32'h0,  1,32'h8,32'h00221821,32'hC,0, 1,5,3,1));
    tab.push_back(mk(1,1,1,1,32'h14, 0,32'h8,32'h00221821,32'h14,0, 0,0,0,0));
    tab.push_back(mk(1,1,1,0,32'h0,  1,32'h14,32'h00853024,32'h18,0, 0,0,0,0));
    tab.push_back(mk(1,1,1,1,32'h7C, 0,32'h14,32'h00853024,32'h7C,0, 0,0,0,0));
    tab.push_back(mk(1,1,1,0,32'h0,  1,32'h7C,32'h0,32'h80,0, 0,0,0,0));
    tab.push_back(mk(1,1,1,0,32'h0,  1,32'h80,32'h0,32'h84,0, 0,0,0,0));
    tab.push_back(mk(1,1,1,1,32'hFFFF_FFFC, 0,32'h80,32'h0,32'hFFFF_FFFC,0, 0,0,0,0));
    tab.push_back(mk(1,1,1,0,32'h0,  1,32'hFFFF_FFFC,32'h0,32'h0,0, 0,0,0,0));
    tab.push_back(mk(1,1,1,0,32'h0,  1,32'h0,32'h2401000A,32'h4,0, 0,0,0,0));
    tab.push_back(mk(1,0,0,0,32'h0,  1,32'h0,32'h2401000A,32'h4,0, 0,0,0,0));
    tab.push_back(mk(1,0,1,0,32'h0,  0,32'h0,32'h2401000A,32'h4,0, 0,0,0,0));
    tab.push_back(mk(1,0,1,1,32'h10, 0,32'h0,32'h2401000A,32'h10,0, 0,0,0,0));
    tab.push_back(mk(1,1,1,0,32'h0,  0,32'h0,32'h2401000A,32'h10,0, 0,0,0,0));
    tab.push_back(mk(1,1,1,0,32'h0,  1,32'h10,32'h0,32'h14,0, 0,0,0,0));
    tab.push_back(mk(1,1,1,1,32'h13, 0,32'h10,32'h0,32'h14,1, 1,11,4,4));

    for (int i = 0; i < tab.size(); i++) run_row(tab[i], i);

    // HALT holds for 10 cycles, then an aligned redirect to 0 is ignored.
    for (int i = 0; i < 11; i++) begin
      row_t h;
      h = mk(1,1,1,(i == 10),32'h0, 0,32'h10,32'h0,32'h14,1,
             (i == 10),11,4,4);
      run_row(h, 100 + i);
    end

    tab.delete();
    tab.push_back(mk(0,1,1,0,32'h0,  0,32'h0,32'h0,32'h0,0, 1,0,0,0));
    tab.push_back(mk(1,1,1,0,32'h0,  0,32'h0,32'h0,32'h0,0, 0,0,0,0));
    tab.push_back(mk(1,1,1,0,32'h0,  1,32'h0,32'h2401000A,32'h4,0, 0,0,0,0));
    tab.push_back(mk(1,1,0,0,32'h0,  1,32'h0,32'h2401000A,32'h4,0, 1,1,1,0));
    tab.push_back(mk(0,1,0,1,32'h40, 0,32'h0,32'h0,32'h0,0, 1,0,0,0));
    tab.push_back(mk(1,1,1,0,32'h0,  0,32'h0,32'h0,32'h0,0, 0,0,0,0));
    tab.push_back(mk(1,1,1,0,32'h0,  1,32'h0,32'h2401000A,32'h4,0, 1,1,0,0));

    for (int i = 0; i < tab.size(); i++) run_row(tab[i], 200 + i);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
